// File: rtl/mem_responder_pkg.sv
// mem_responder_pkg: shared state encoding, address checks and statistic limits
package mem_responder_pkg;
    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
    localparam logic [1:0] ADR_ALIGN_MASK = 2'b11;
    localparam logic [15:0] STAT_MAX = 16'hFFFF;
    function automatic logic adr_err(input logic [31:0] adr, input int depth);
        return (|(adr[1:0] & ADR_ALIGN_MASK)) || ({2'b00, adr[31:2]} >= 32'(depth));
    endfunction
endpackage

// File: rtl/mem_responder_if.sv
// mem_responder_if: request/response bus between the datapath and the memory responder
interface mem_responder_if;
    logic        Req;
    logic        MemWrite;
    logic [31:0] Adr;
    logic [31:0] WriteData;
    logic [31:0] ReadData;
    logic        Ready;
    logic        Err;
    logic [15:0] RdCount;
    logic [15:0] WrCount;
    modport master(output Req, MemWrite, Adr, WriteData, input ReadData, Ready, Err, RdCount, WrCount);
    modport slave(input Req, MemWrite, Adr, WriteData, output ReadData, Ready, Err, RdCount, WrCount);
endinterface

// File: rtl/mem_responder_mem_array.sv
// mem_array: DEPTH x 32 single-port synchronous RAM, read-old-data, no reset
module mem_array #(
    parameter int DEPTH = 64,
    parameter int AW = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wd,
    output logic [31:0]   rd
);
    logic [31:0] mem [DEPTH];
    always_ff @(posedge clk) begin
        if (we) mem[addr] <= wd;
        rd <= mem[addr];
    end
endmodule

// File: rtl/mem_responder.sv
// mem_responder: word memory with Req/Ready handshake and programmable wait states.
// Define MEM_RESPONDER_STATS_EN to build the saturating read/write completion counters.
module mem_responder
    import mem_responder_pkg::*;
#(
    parameter int DEPTH = 64,
    parameter int WAIT_CYCLES = 2
) (
    input logic clk,
    input logic reset,
    mem_responder_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [3:0] WAIT_LAST = 4'(WAIT_CYCLES - 1);
    state_t state, state_nxt;
    logic [3:0]  wait_cnt;
    logic        wr_q;
    logic [31:0] adr_q, wd_q, hold_q, rd;
    logic        accept, enter_resp, acc_wr, acc_err, we;
    logic [31:0] acc_adr, acc_wd;
    // In IDLE the live bus feeds the RAM so a zero-wait access can commit on its accepting edge
    always_comb begin
        accept     = state == IDLE && bus.Req;
        state_nxt  = state == RESP ? IDLE
                   : state == WAIT ? (wait_cnt == WAIT_LAST ? RESP : WAIT)
                   : !accept ? IDLE : WAIT_CYCLES == 0 ? RESP : WAIT;
        enter_resp = state != RESP && state_nxt == RESP;
        acc_wr     = state == IDLE ? bus.MemWrite : wr_q;
        acc_adr    = state == IDLE ? bus.Adr : adr_q;
        acc_wd     = state == IDLE ? bus.WriteData : wd_q;
        acc_err    = adr_err(acc_adr, DEPTH);
        we         = enter_resp && acc_wr && !acc_err;
        bus.Ready  = state == RESP;
        bus.Err    = bus.Ready && adr_err(adr_q, DEPTH);
        bus.ReadData = bus.Ready && !wr_q ? (bus.Err ? 32'h0 : rd) : hold_q;
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            wait_cnt <= '0;
            wr_q     <= 1'b0;
            adr_q    <= '0;
            wd_q     <= '0;
            hold_q   <= '0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= state == WAIT ? wait_cnt + 4'd1 : 4'd0;
            if (accept) {wr_q, adr_q, wd_q} <= {bus.MemWrite, bus.Adr, bus.WriteData};
            if (bus.Ready) hold_q <= bus.ReadData;
        end
    end
    mem_array #(.DEPTH(DEPTH)) u_array (
        .clk (clk),
        .we  (we),
        .addr(acc_adr[AW+1:2]),
        .wd  (acc_wd),
        .rd  (rd)
    );
`ifdef MEM_RESPONDER_STATS_EN
    logic [15:0] rd_cnt, wr_cnt;
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_cnt <= '0;
            wr_cnt <= '0;
        end else if (bus.Ready && !bus.Err) begin
            if (wr_q && wr_cnt != STAT_MAX) wr_cnt <= wr_cnt + 16'd1;
            if (!wr_q && rd_cnt != STAT_MAX) rd_cnt <= rd_cnt + 16'd1;
        end
    end
    assign bus.RdCount = rd_cnt;
    assign bus.WrCount = wr_cnt;
`else
    assign bus.RdCount = 16'h0000;
    assign bus.WrCount = 16'h0000;
`endif
endmodule
